// File: rtl/q_value_update_pkg.sv
// q_value_update_pkg
//   Shared definitions for the EER-RL Q-value update stage. It holds the
//   memory geometry, the node memory map, the default fixed-point
//   coefficients, the FSM state encoding and two small helper functions.
//   The package has no ports.
package q_value_update_pkg;

  localparam int MEM_DEPTH  = 2048;
  localparam int MEM_WIDTH  = 8;
  localparam int WORD_WIDTH = 16;

  // Word addresses in node memory.
  localparam logic [10:0] MYQ_ADDR    = 11'h070;  // own Q value, 8.8
  localparam logic [10:0] ENERGY_ADDR = 11'h06C;  // energyLeft, 2.14
  localparam logic [10:0] HOPS_BASE   = 11'h072;  // hop table, 2 words per entry

  // Coefficients. All are unsigned 8.8 except the threshold, which is 2.14.
  localparam logic [15:0] ALPHA            = 16'h0080;
  localparam logic [15:0] GAMMA            = 16'h00E6;
  localparam logic [15:0] HOP_PENALTY      = 16'h0010;
  localparam logic [15:0] QMAX             = 16'h0100;
  localparam logic [15:0] ENERGY_THRESHOLD = 16'h00CD;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_RD_MYQ,
    ST_RD_ENERGY,
    ST_RD_HOPS,
    ST_CALC_R,
    ST_MUL_G,
    ST_MUL_A,
    ST_WRITE,
    ST_DONE
  } state_t;

  function automatic logic [10:0] hop_addr(input logic [9:0] idx);
    return HOPS_BASE + {idx, 1'b0};
  endfunction

  // The sum is non-negative when bit 18 is clear, so the upper compare can be
  // done unsigned.
  function automatic logic [15:0] clamp_q(input logic signed [18:0] sum);
    if (sum[18])
      return 16'h0000;
    else if (sum[17:0] > {2'b00, QMAX})
      return QMAX;
    else
      return sum[15:0];
  endfunction

endpackage

// File: rtl/q_value_update_fx_mul.sv
// fx_mul_8p8
//   Signed 8.8 fixed-point multiplier with a registered output. The block
//   computes p = (a * b) >>> 8, where a is signed and b is an unsigned
//   coefficient. The product is truncated to 18 bits.
// Ports
//   clock  in   1   system clock
//   rst    in   1   asynchronous active-high reset
//   a_i    in   18  signed operand
//   b_i    in   16  unsigned 8.8 operand
//   p_o    out  18  registered signed product, valid one cycle after the operands
module fx_mul_8p8
  import q_value_update_pkg::*;
(
  input  logic               clock,
  input  logic               rst,
  input  logic signed [17:0] a_i,
  input  logic        [15:0] b_i,
  output logic signed [17:0] p_o
);

  logic signed [34:0] prod;
  logic signed [17:0] p_q;
  logic               unused_prod_bits;

  assign prod = 35'(a_i) * 35'($signed({1'b0, b_i}));

  // Taking bits [25:8] of the signed product is the same as an arithmetic
  // shift right by 8 followed by truncation to 18 bits.
  assign unused_prod_bits = ^{prod[34:26], prod[7:0]};

  always_ff @(posedge clock or posedge rst) begin
    if (rst) p_q <= '0;
    else     p_q <= prod[25:8];
  end

  assign p_o = p_q;

endmodule

// File: rtl/q_value_update.sv
// q_value_update
//   EER-RL Q-learning update for this node's own Q value:
//     Q' = clamp(Q + ALPHA*(R + GAMMA*bestvalue - Q), 0, QMAX)
//     R  = (energy >> 6) - HOP_PENALTY*hops
//   Operands are read from node memory over the shared word port, and Q' is
//   written back to MYQ_ADDR. Count the cycle in which start is sampled as
//   cycle 1; wr_en is then high in cycle 8, and done rises in cycle 9.
// Optional feature (macro QUPD_ENERGY_THRESHOLD_EN)
//   When energy < ENERGY_THRESHOLD, the block writes Q' = 0 directly from
//   CALC_R and raises low_energy. Without the macro, low_energy is tied to 0.
// Ports
//   clock, rst             clock and asynchronous active-high reset
//   en                     block enable; low returns the FSM to IDLE
//   start                  begin one update (sampled in START)
//   data_in     [15:0]     memory read word, valid the cycle after address
//   besthop     [15:0]     chosen neighbour index (bits [9:0] are used)
//   bestvalue   [15:0]     chosen neighbour Q value, 8.8
//   address     [10:0]     memory word address
//   wr_en, data_out[15:0]  one-cycle write of Q'
//   qvalue_out  [15:0]     last Q' computed
//   low_energy, done       status outputs
module q_value_update
  import q_value_update_pkg::*;
(
  input  logic        clock,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  input  logic [15:0] data_in,
  input  logic [15:0] besthop,
  input  logic [15:0] bestvalue,
  output logic [10:0] address,
  output logic        wr_en,
  output logic [15:0] data_out,
  output logic [15:0] qvalue_out,
  output logic        low_energy,
  output logic        done
);

  state_t             state_q, state_d;
  logic        [9:0]  besthop_q, besthop_d;
  logic        [15:0] bestvalue_q, bestvalue_d;
  logic        [15:0] myq_q, myq_d;
  logic        [15:0] energy_q, energy_d;
  logic        [15:0] hops_q, hops_d;
  logic signed [17:0] r_q, r_d;
  logic        [15:0] qvalue_q, qvalue_d;
  logic               done_q, done_d;
  logic               low_q, low_d;

  logic signed [17:0] mul_a, mul_p, t_val;
  logic        [15:0] mul_b, q_new;
  logic signed [18:0] sum_val;
  logic               unused_in_bits;

  assign unused_in_bits = ^{besthop[15:10], energy_q[5:0]};

  // One multiplier is shared. MUL_G forms GAMMA*bestvalue, and MUL_A reuses
  // that result to build T and then forms ALPHA*T.
  assign t_val   = r_q + mul_p - $signed({2'b00, myq_q});
  assign mul_a   = (state_q == ST_MUL_G) ? $signed({2'b00, bestvalue_q}) : t_val;
  assign mul_b   = (state_q == ST_MUL_G) ? GAMMA : ALPHA;
  assign sum_val = $signed({3'b000, myq_q}) + $signed({mul_p[17], mul_p});
  assign q_new   = low_q ? 16'h0000 : clamp_q(sum_val);

  fx_mul_8p8 u_mul (
    .clock (clock),
    .rst   (rst),
    .a_i   (mul_a),
    .b_i   (mul_b),
    .p_o   (mul_p)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      besthop_q   <= '0;
      bestvalue_q <= '0;
      myq_q       <= '0;
      energy_q    <= '0;
      hops_q      <= '0;
      r_q         <= '0;
      qvalue_q    <= '0;
      done_q      <= 1'b0;
      low_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      besthop_q   <= besthop_d;
      bestvalue_q <= bestvalue_d;
      myq_q       <= myq_d;
      energy_q    <= energy_d;
      hops_q      <= hops_d;
      r_q         <= r_d;
      qvalue_q    <= qvalue_d;
      done_q      <= done_d;
      low_q       <= low_d;
    end
  end

  // The address presented in each state is the word needed in the next
  // state, because memory data arrives one cycle after the address.
  always_comb begin
    state_d     = state_q;
    besthop_d   = besthop_q;
    bestvalue_d = bestvalue_q;
    myq_d       = myq_q;
    energy_d    = energy_q;
    hops_d      = hops_q;
    r_d         = r_q;
    qvalue_d    = qvalue_q;
    done_d      = done_q;
    low_d       = low_q;
    address     = MYQ_ADDR;
    wr_en       = 1'b0;
    data_out    = 16'h0000;

    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d     = ST_START;
          done_d      = 1'b0;
          besthop_d   = '0;
          bestvalue_d = '0;
          myq_d       = '0;
          energy_d    = '0;
          hops_d      = '0;
          r_d         = '0;
        end
      end
      ST_START: begin
        if (start) begin
          besthop_d   = besthop[9:0];
          bestvalue_d = bestvalue;
          done_d      = 1'b0;
          low_d       = 1'b0;
          state_d     = ST_RD_MYQ;
        end
      end
      ST_RD_MYQ: begin
        myq_d   = data_in;
        address = ENERGY_ADDR;
        state_d = ST_RD_ENERGY;
      end
      ST_RD_ENERGY: begin
        energy_d = data_in;
        address  = hop_addr(besthop_q);
        state_d  = ST_RD_HOPS;
      end
      ST_RD_HOPS: begin
        hops_d  = data_in;
        state_d = ST_CALC_R;
      end
      ST_CALC_R: begin
        r_d     = $signed({8'b0, energy_q[15:6]} - 18'(HOP_PENALTY) * 18'(hops_q));
        state_d = ST_MUL_G;
`ifdef QUPD_ENERGY_THRESHOLD_EN
        if (energy_q < ENERGY_THRESHOLD) begin
          low_d   = 1'b1;
          state_d = ST_WRITE;
        end
`endif
      end
      ST_MUL_G: state_d = ST_MUL_A;
      ST_MUL_A: state_d = ST_WRITE;
      ST_WRITE: begin
        wr_en    = 1'b1;
        data_out = q_new;
        qvalue_d = q_new;
        done_d   = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (!start) state_d = ST_START;
      end
      default: state_d = ST_IDLE;
    endcase

    // Dropping en takes priority. It also suppresses a write that is in
    // flight, so memory never sees a partial update.
    if (!en) begin
      state_d  = ST_IDLE;
      done_d   = 1'b0;
      qvalue_d = qvalue_q;
      wr_en    = 1'b0;
      data_out = 16'h0000;
    end
  end

  assign qvalue_out = qvalue_q;
  assign done       = done_q;
`ifdef QUPD_ENERGY_THRESHOLD_EN
  assign low_energy = low_q;
`else
  assign low_energy = 1'b0;
`endif

endmodule

// File: tb/tb_q_value_update.sv
module tb_q_value_update;

  logic        clock = 1'b0;
  logic        rst, en, start;
  logic [15:0] data_in, besthop, bestvalue;
  logic [10:0] address;
  logic        wr_en, low_energy, done;
  logic [15:0] data_out, qvalue_out;

  logic [15:0] mem [2048];
  int          wr_count = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

`ifdef QUPD_ENERGY_THRESHOLD_EN
  localparam bit LOW_EN = 1'b1;
`else
  localparam bit LOW_EN = 1'b0;
`endif

  always #5 clock = ~clock;

  q_value_update dut (
    .clock      (clock),
    .rst        (rst),
    .en         (en),
    .start      (start),
    .data_in    (data_in),
    .besthop    (besthop),
    .bestvalue  (bestvalue),
    .address    (address),
    .wr_en      (wr_en),
    .data_out   (data_out),
    .qvalue_out (qvalue_out),
    .low_energy (low_energy),
    .done       (done)
  );

  // Synchronous-read word memory: data follows the address by one cycle.
  always @(posedge clock) begin
    if (wr_en) begin
      mem[address] <= data_out;
      wr_count     <= wr_count + 1;
    end
    data_in <= mem[address];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_low(input logic [15:0] e);
    return LOW_EN && (e < 16'h00CD);
  endfunction

  // One update, starting from the DONE cycle of the previous run (or from
  // the cycle before START when first_run is set). The expected value
  // exp_formula is the hand-computed result when the energy threshold does
  // not apply.
  task automatic do_update(input string tag, input logic [15:0] q, input logic [15:0] e,
                           input logic [15:0] hb, input logic [15:0] h, input logic [15:0] bv,
                           input logic [15:0] exp_formula, input bit first_run);
    logic        lowp;
    logic [15:0] exp_w;
    logic [10:0] ha;
    int          wait_n, base;
    lowp   = is_low(e);
    exp_w  = lowp ? 16'h0000 : exp_formula;
    wait_n = lowp ? 4 : 6;
    ha     = 11'h072 + {hb[9:0], 1'b0};
    mem[11'h070] = q;
    mem[11'h06C] = e;
    mem[ha]      = h;
    besthop      = hb;
    bestvalue    = bv;
    @(negedge clock);                       // START
    if (!first_run) check_val({tag, ":done_hold"}, 32'(done), 32'd1);
    start = 1'b1;
    @(negedge clock);                       // RD_MYQ
    start     = 1'b0;
    besthop   = 16'h03FF;                   // must be ignored after sampling
    bestvalue = 16'hFFFF;
    base      = wr_count;
    check_val({tag, ":done_clr"}, 32'(done), 32'd0);
    @(negedge clock);                       // RD_ENERGY
    check_val({tag, ":hop_addr"}, 32'(address), 32'(ha));
    start = 1'b1;                           // ignored while busy
    @(negedge clock);                       // RD_HOPS
    start = 1'b0;
    repeat (wait_n - 3) @(negedge clock);
    check_val({tag, ":pre_wr"}, 32'(wr_en), 32'd0);
    @(negedge clock);                       // WRITE
    check_val({tag, ":wr_en"}, 32'(wr_en), 32'd1);
    check_val({tag, ":wr_addr"}, 32'(address), 32'h070);
    check_val({tag, ":data_out"}, 32'(data_out), 32'(exp_w));
    @(negedge clock);                       // DONE
    check_val({tag, ":post_wr"}, 32'(wr_en), 32'd0);
    check_val({tag, ":done"}, 32'(done), 32'd1);
    check_val({tag, ":qvalue"}, 32'(qvalue_out), 32'(exp_w));
    check_val({tag, ":low"}, 32'(low_energy), 32'(lowp));
    check_val({tag, ":mem"}, 32'(mem[11'h070]), 32'(exp_w));
    check_val({tag, ":n_wr"}, 32'(wr_count - base), 32'd1);
  endtask

  initial begin
    int base;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    rst = 1'b1; en = 1'b0; start = 1'b0;
    besthop = 16'h0000; bestvalue = 16'h0000; data_in = 16'h0000;
    repeat (2) @(negedge clock);
    check_val("rst:address", 32'(address), 32'h070);
    check_val("rst:wr_en", 32'(wr_en), 32'd0);
    check_val("rst:data_out", 32'(data_out), 32'd0);
    check_val("rst:qvalue", 32'(qvalue_out), 32'd0);
    check_val("rst:low", 32'(low_energy), 32'd0);
    check_val("rst:done", 32'(done), 32'd0);
    rst = 1'b0; en = 1'b1;

    // The raw sum is 0x016B, which exceeds QMAX=0x0100, so the clamp applies.
    do_update("r1", 16'h0100, 16'h4000, 16'd0, 16'd1, 16'h0100, 16'h0100, 1'b1);
    // Here the sum is 0x100 - 0x15 = 0x00EB (negative D path).
    do_update("r2", 16'h0100, 16'h0000, 16'd1, 16'd1, 16'h0100, 16'h00EB, 1'b0);
    // Here the sum is -0x20, which clamps to 0.
    do_update("r3", 16'h0000, 16'h0000, 16'd2, 16'd4, 16'h0000, 16'h0000, 1'b0);
    // With besthop=3 the hop word is at 0x078; R=0x20, T=-0x60, D=-0x30, so the result is 0x50.
    mem[11'h072] = 16'h0009;
    do_update("r4", 16'h0080, 16'h1000, 16'd3, 16'd2, 16'h0000, 16'h0050, 1'b0);
    // R=0x80, G=0x73, T=0xB3, D=0x59, so the result is 0x99.
    do_update("r5", 16'h0040, 16'h2000, 16'd5, 16'd0, 16'h0080, 16'h0099, 1'b0);
    // energy=0x00C0: R=-0xD, T=-0x27, D=-0x14, so the formula gives 0xEC.
    do_update("r6", 16'h0100, 16'h00C0, 16'd1, 16'd1, 16'h0100, 16'h00EC, 1'b0);

    // Dropping en in WRITE must suppress the write and return the FSM to IDLE.
    mem[11'h070] = 16'h0100; mem[11'h06C] = 16'h4000; mem[11'h072] = 16'd1;
    besthop = 16'd0; bestvalue = 16'h0100;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0; base = wr_count;
    repeat (6) @(negedge clock);
    en = 1'b0;
    #1 check_val("en:wr_gate", 32'(wr_en), 32'd0);
    @(negedge clock);
    check_val("en:n_wr", 32'(wr_count - base), 32'd0);
    check_val("en:done", 32'(done), 32'd0);
    check_val("en:mem", 32'(mem[11'h070]), 32'h0100);
    check_val("en:qvalue", 32'(qvalue_out), 32'(is_low(16'h00C0) ? 16'h0000 : 16'h00EC));
    en = 1'b1;

    // Asserting reset in MUL_G must abort the update with no write.
    @(negedge clock);                       // START
    start = 1'b1;
    @(negedge clock); start = 1'b0; base = wr_count;
    repeat (4) @(negedge clock);            // MUL_G
    rst = 1'b1;
    #1;
    check_val("rstmid:wr_en", 32'(wr_en), 32'd0);
    check_val("rstmid:done", 32'(done), 32'd0);
    check_val("rstmid:qvalue", 32'(qvalue_out), 32'd0);
    @(negedge clock);
    rst = 1'b0;
    check_val("rstmid:n_wr", 32'(wr_count - base), 32'd0);
    do_update("r7", 16'h0100, 16'h0000, 16'd1, 16'd1, 16'h0100, 16'h00EB, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
